vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter H_PIX, 640, words (pixels) fetched per display line.
REQ-002 Parameter V_LINES, 480, number of valid line indices.
REQ-003 Parameter AW, 19, frame-buffer word address width.
REQ-004 Parameter DW, 24, pixel/data width (RGB888).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rstn  in  1  reset, asynchronous and active-low.
REQ-007 line_req  in  1  one-cycle pulse: prefetch line line_idx.
REQ-008 line_idx  in  12  line number; sampled only when line_req=1.
REQ-009 line_done  out  1  one-cycle pulse: all H_PIX words of the line written to the line buffer.
REQ-010 wr_req  in  1  writer request; held until wr_ack.
REQ-011 wr_addr  in  AW  writer word address; held stable while wr_req=1.
REQ-012 wr_data  in  DW  writer data; held stable while wr_req=1.
REQ-013 wr_ack  out  1  combinational: write accepted this cycle.
REQ-014 mem_cmd_valid  out  1  memory command valid.
REQ-015 mem_cmd_ready  in  1  memory accepts the command this cycle.
REQ-016 mem_cmd_we  out  1  1=write, 0=read.
REQ-017 mem_cmd_addr  out  AW  command address.
REQ-018 mem_cmd_wdata  out  DW  write data.
REQ-019 mem_rd_valid  in  1  read data valid; returns in command order, any latency >= 1.
REQ-020 mem_rd_data  in  DW  read data.
REQ-021 lb_we, lb_bank, lb_addr[10:0], lb_wdata[DW-1:0]  out  line-buffer write port; lb_bank selects ping-pong half.
REQ-022 busy  out  1  state != IDLE.
REQ-023 err  out  1  sticky: dropped line request.

Function
REQ-024 FSM states: IDLE, RD_ISSUE, RD_DRAIN, WR.
REQ-025 IDLE: a pending line request takes priority over wr_req; pending line -> RD_ISSUE; else wr_req=1 -> WR; else stay.
REQ-026 A line_req arriving in IDLE or WR sets the pending flag and latches line_idx; a line_req arriving in IDLE is serviced starting the next cycle.
REQ-027 A line_req arriving in RD_ISSUE or RD_DRAIN, or while a request is already pending, is dropped and sets err.
REQ-028 A line_req with line_idx >= V_LINES is dropped and sets err.
REQ-029 Read base address = line_idx*H_PIX, truncated to AW bits; the issue address increments by 1 per accepted command.
REQ-030 RD_ISSUE: mem_cmd_valid=1, mem_cmd_we=0; the issue count increments on valid&&ready; after the H_PIX-th handshake -> RD_DRAIN.
REQ-031 Every mem_rd_valid during RD_ISSUE or RD_DRAIN produces, in the same cycle, lb_we=1, lb_addr=return count, lb_wdata=mem_rd_data, lb_bank=current bank; the return count then increments.
REQ-032 When the H_PIX-th word returns (in RD_ISSUE or RD_DRAIN):
  - line_done pulses in the cycle after that return;
  - the bank toggles;
  - state -> IDLE.
REQ-033 mem_rd_valid in IDLE or WR is ignored (no lb_we).
REQ-034 WR: mem_cmd_valid=1, mem_cmd_we=1, mem_cmd_addr=wr_addr, mem_cmd_wdata=wr_data; wr_ack = (state==WR)&&mem_cmd_ready; on ack -> IDLE.
REQ-035 No write is granted between entering RD_ISSUE and the matching line_done.
REQ-036 mem_cmd_valid, once asserted, is held with a stable command until ready.
REQ-037 mem_cmd_wdata = 0 whenever mem_cmd_we = 0.
REQ-038 Counters are 11 bits and reset to 0 at the start of each line.

Reset
REQ-039 rstn=0 forces immediately:
  - state=IDLE; pending, err, bank, counters = 0;
  - all outputs 0.
REQ-040 Reset mid-operation abandons the line with no line_done; read data returned after reset release is ignored.

Verification
REQ-041 line_req, line_idx=2, ready=1, read latency 3 -> addresses 1280..1919 issued; 640 lb writes at lb_addr 0..639, bank 0; line_done once; next line uses bank 1.
REQ-042 wr_req held during a line fetch -> no write issued until after line_done; then exactly one write, wr_ack one cycle.
REQ-043 line_req and wr_req asserted in the same cycle in IDLE -> read serviced first, then the write.
REQ-044 Second line_req during RD_DRAIN, and line_idx=480 -> both dropped, err=1 and remains set until reset.
REQ-045 mem_cmd_ready toggled randomly -> command held stable while stalled, no duplicate or skipped addresses.
REQ-046 rstn pulsed low at word 300 -> outputs 0 at once; a fresh line after reset starts at lb_addr 0, bank 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one frame-buffer memory port between a display line prefetcher
//   (reads H_PIX words of one line into a ping-pong line buffer) and a pixel
//   writer. A pending line request always wins over the writer.
//
// Ports
//   clk, rstn          : clock (rising edge), asynchronous active-low reset
//   line_req/line_idx  : one-cycle pulse asking for line line_idx
//   line_done          : one-cycle pulse after the last word of a line landed
//   wr_req/addr/data   : writer request, held until wr_ack
//   wr_ack             : combinational, write command accepted this cycle
//   mem_cmd_*          : memory command channel
//   mem_rd_valid/data  : in-order read returns, latency >= 1
//   lb_we/bank/addr/wdata : line-buffer write port (bank = ping-pong half)
//   busy, err          : FSM not idle, sticky dropped-line flag
//   fsm_state          : current FSM state, for observation
//
// Handshake: a memory command transfers on a rising edge where
// mem_cmd_valid && mem_cmd_ready; once valid is raised the command
// (we, addr, wdata) is held unchanged until that edge.
module vga_fb_arbiter #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480,
  parameter int AW      = 19,
  parameter int DW      = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          line_req,
  input  logic [11:0]   line_idx,
  output logic          line_done,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          mem_cmd_valid,
  input  logic          mem_cmd_ready,
  output logic          mem_cmd_we,
  output logic [AW-1:0] mem_cmd_addr,
  output logic [DW-1:0] mem_cmd_wdata,
  input  logic          mem_rd_valid,
  input  logic [DW-1:0] mem_rd_data,
  output logic          lb_we,
  output logic          lb_bank,
  output logic [10:0]   lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          busy,
  output logic          err,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } state_t;

  localparam logic [10:0] LAST_WORD = 11'(H_PIX - 1);

  state_t        state, state_next;
  logic          pending;
  logic [11:0]   pend_idx;
  logic          bank;
  logic [10:0]   issue_cnt;
  logic [10:0]   ret_cnt;
  logic [AW-1:0] rd_addr;

  logic          reading;
  logic          idx_ok;
  logic          line_accept;
  logic          start_line;
  logic [11:0]   start_idx;
  logic [AW-1:0] base_addr;
  logic          cmd_fire;
  logic          rd_fire;
  logic          last_ret;

  assign reading     = (state == RD_ISSUE) || (state == RD_DRAIN);
  assign idx_ok      = 32'(line_idx) < 32'(V_LINES);
  // Only one request can be outstanding: accepted in IDLE or WR when
  // nothing is pending; everything else is dropped and flagged.
  assign line_accept = line_req && idx_ok && !pending &&
                       ((state == IDLE) || (state == WR));
  // A request arriving in IDLE starts the fetch straight away, without
  // waiting a cycle in the pending flag.
  assign start_line  = (state == IDLE) && (pending || line_accept);
  assign start_idx   = pending ? pend_idx : line_idx;
  assign base_addr   = AW'(start_idx) * AW'(H_PIX);
  assign cmd_fire    = mem_cmd_valid && mem_cmd_ready;
  assign rd_fire     = reading && mem_rd_valid;
  assign last_ret    = rd_fire && (ret_cnt == LAST_WORD);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_line) begin
          state_next = RD_ISSUE;
        end else if (wr_req) begin
          state_next = WR;
        end
      end
      RD_ISSUE: begin
        if (last_ret) begin
          state_next = IDLE;
        end else if (cmd_fire && (issue_cnt == LAST_WORD)) begin
          state_next = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (last_ret) begin
          state_next = IDLE;
        end
      end
      WR: begin
        if (mem_cmd_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory command outputs; wdata stays zero for reads.
  always_comb begin
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    wr_ack        = 1'b0;
    case (state)
      RD_ISSUE: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = rd_addr;
      end
      WR: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = 1'b1;
        mem_cmd_addr  = wr_addr;
        mem_cmd_wdata = wr_data;
        wr_ack        = mem_cmd_ready;
      end
      default: ;
    endcase
  end

  // Returns are written through to the line buffer in the same cycle.
  assign lb_we     = rd_fire;
  assign lb_bank   = bank;
  assign lb_addr   = ret_cnt;
  assign lb_wdata  = rd_fire ? mem_rd_data : '0;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Datapath: request bookkeeping, counters, bank
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending   <= 1'b0;
      pend_idx  <= '0;
      err       <= 1'b0;
      bank      <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      rd_addr   <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= last_ret;

      if (line_req && !line_accept) begin
        err <= 1'b1;
      end

      if (line_accept && (state == WR)) begin
        pending  <= 1'b1;
        pend_idx <= line_idx;
      end else if (start_line) begin
        pending <= 1'b0;
      end

      if (start_line) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        rd_addr   <= base_addr;
      end else begin
        if ((state == RD_ISSUE) && cmd_fire) begin
          issue_cnt <= issue_cnt + 11'd1;
          rd_addr   <= rd_addr + AW'(1);
        end
        if (rd_fire) begin
          ret_cnt <= ret_cnt + 11'd1;
        end
      end

      if (last_ret) begin
        bank <= ~bank;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
//   Bench for vga_fb_arbiter: a memory responder with random ready and
//   random in-order read latency, a monitor that logs every command, line
//   buffer write and pulse, and a line-level reference model (a line idx
//   yields H_PIX addresses idx*H_PIX+i and H_PIX buffer writes at 0..H_PIX-1
//   in bank = lines completed since reset, mod 2).
module tb_vga_fb_arbiter;
  localparam int H_PIX   = 640;
  localparam int V_LINES = 480;
  localparam int AW      = 19;
  localparam int DW      = 24;
  localparam int LBW     = 1 + 11 + DW;
  localparam int BUDGET  = 6000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          line_req;
  logic [11:0]   line_idx;
  logic          line_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_cmd_wdata;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          lb_we;
  logic          lb_bank;
  logic [10:0]   lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          busy;
  logic          err;
  logic [1:0]    fsm_state;

  vga_fb_arbiter #(.H_PIX(H_PIX), .V_LINES(V_LINES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .line_req(line_req), .line_idx(line_idx), .line_done(line_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit rand_lat = 1'b0;
  int fixed_lat = 3;
  int done_cnt = 0, done_cyc = -1;
  int wr_ack_cnt = 0, wr_ack_cyc = -1;
  int first_rd_cyc = -1, first_wr_cyc = -1;
  int stall_viol = 0, wdata_viol = 0, ack_viol = 0;
  bit prev_stall = 1'b0;
  logic [AW+DW:0] prev_cmd, cur_cmd;
  bit exp_bank = 1'b0;
  logic [LBW-1:0] bad_act, bad_exp;
  logic [AW-1:0] bad_a_act, bad_a_exp;

  logic [LBW-1:0]   exp_q[$];
  logic [LBW-1:0]   lb_log[$];
  logic [AW-1:0]    exp_addr_q[$];
  logic [AW-1:0]    rd_addr_log[$];
  logic [AW+DW-1:0] wr_log[$];
  rd_t              rq[$];
  logic [DW-1:0]    wmem [int];

  // Frame-buffer contents: written words, else a fixed hash of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] h;
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    h = 32'(a) * 32'h9E3779B1;
    return h[DW+6:7] ^ 24'hA5C33C;
  endfunction

  // ---------------- memory responder + monitor ----------------
  initial begin : env
    mem_cmd_ready = 1'b0;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mem_cmd_ready = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = '0;
        prev_stall    = 1'b0;
      end else begin
        cyc++;
        mem_cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = rq[0].data;
          void'(rq.pop_front());
        end else begin
          mem_rd_valid = 1'b0;
          mem_rd_data  = '0;
        end
        #1;
        if (mem_cmd_valid && !mem_cmd_we && mem_cmd_wdata !== '0) wdata_viol++;
        cur_cmd = {mem_cmd_we, mem_cmd_addr, mem_cmd_wdata};
        if (prev_stall && (!mem_cmd_valid || cur_cmd !== prev_cmd)) stall_viol++;
        prev_stall = mem_cmd_valid && !mem_cmd_ready;
        prev_cmd   = cur_cmd;
        if (wr_ack !== (mem_cmd_valid && mem_cmd_we && mem_cmd_ready)) ack_viol++;
        if (mem_cmd_valid && mem_cmd_ready) begin
          if (mem_cmd_we) begin
            wmem[int'(mem_cmd_addr)] = mem_cmd_wdata;
            wr_log.push_back({mem_cmd_addr, mem_cmd_wdata});
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
          end else begin
            rd_addr_log.push_back(mem_cmd_addr);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rq.push_back('{data: mem_word(mem_cmd_addr),
                           due: cyc + (rand_lat ? int'($urandom_range(1, 6)) : fixed_lat)});
          end
        end
        if (wr_ack) begin
          wr_ack_cnt++;
          wr_ack_cyc = cyc;
        end
        if (lb_we) lb_log.push_back({lb_bank, lb_addr, lb_wdata});
        if (line_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    lb_log.delete();
    exp_addr_q.delete();
    rd_addr_log.delete();
    wr_log.delete();
  endtask

  // Reference model of one accepted line.
  task automatic expect_line(input int idx);
    logic [AW-1:0] a;
    for (int i = 0; i < H_PIX; i++) begin
      a = AW'(idx * H_PIX + i);
      exp_addr_q.push_back(a);
      exp_q.push_back({exp_bank, 11'(i), mem_word(a)});
    end
    exp_bank = ~exp_bank;
  endtask

  task automatic pulse_line(input int idx);
    line_req = 1'b1;
    line_idx = 12'(idx);
    step();
    line_req = 1'b0;
    line_idx = 12'($urandom);
  endtask

  task automatic start_line(input int idx);
    expect_line(idx);
    pulse_line(idx);
  endtask

  task automatic wait_lines(input int target);
    int n = 0;
    while (done_cnt < target && n < BUDGET) begin
      step();
      n++;
    end
  endtask

  // Returns with wr_req already dropped in the ack cycle.
  task automatic wait_ack(input int target);
    int n = 0;
    while (wr_ack_cnt < target && n < BUDGET) begin
      step();
      n++;
    end
    wr_req = 1'b0;
  endtask

  function automatic int lb_diff();
    int n = 0;
    bad_act = '0;
    bad_exp = '0;
    if (lb_log.size() != exp_q.size()) n++;
    for (int i = 0; i < exp_q.size() && i < lb_log.size(); i++) begin
      if (lb_log[i] !== exp_q[i]) begin
        if (n == 0) begin
          bad_act = lb_log[i];
          bad_exp = exp_q[i];
        end
        n++;
      end
    end
    return n;
  endfunction

  function automatic int addr_diff();
    int n = 0;
    bad_a_act = '0;
    bad_a_exp = '0;
    if (rd_addr_log.size() != exp_addr_q.size()) n++;
    for (int i = 0; i < exp_addr_q.size() && i < rd_addr_log.size(); i++) begin
      if (rd_addr_log[i] !== exp_addr_q[i]) begin
        if (n == 0) begin
          bad_a_act = rd_addr_log[i];
          bad_a_exp = exp_addr_q[i];
        end
        n++;
      end
    end
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn     = 1'b0;
    line_req = 1'b0;
    line_idx = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    step();
    checks++;
    if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata, wr_ack} !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got valid=%b we=%b addr=%h wdata=%h ack=%b, expected all 0",
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata, wr_ack);
    end
    checks++;
    if ({lb_we, lb_bank, lb_addr, lb_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_lb: got we=%b bank=%b addr=%0d data=%h, expected all 0",
               lb_we, lb_bank, lb_addr, lb_wdata);
    end
    checks++;
    if ({line_done, busy, err, fsm_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset_status: got done=%b busy=%b err=%b state=%0d, expected all 0",
               line_done, busy, err, fsm_state);
    end
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_line_basic();
    int base;
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
    fixed_lat  = 3;
    clear_logs();
    base = done_cnt;
    start_line(2);
    wait_lines(base + 1);
    repeat (5) step();
    checks++;
    if (done_cnt !== base + 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d pulses, expected 1", done_cnt - base);
    end
    checks++;
    if (addr_diff() != 0) begin
      errors++;
      $display("FAIL basic_addr: %0d bad (n=%0d), got %0d expected %0d",
               addr_diff(), rd_addr_log.size(), bad_a_act, bad_a_exp);
    end
    checks++;
    if (lb_diff() != 0) begin
      errors++;
      $display("FAIL basic_lb: %0d bad (n=%0d), got %h expected %h",
               lb_diff(), lb_log.size(), bad_act, bad_exp);
    end
    clear_logs();
    start_line($urandom_range(0, V_LINES - 1));
    wait_lines(base + 2);
    repeat (3) step();
    checks++;
    if (lb_diff() != 0) begin
      errors++;
      $display("FAIL second_line_bank1: %0d bad (n=%0d), got %h expected %h",
               lb_diff(), lb_log.size(), bad_act, bad_exp);
    end
  endtask

  task automatic test_write_during_fetch();
    int base, ack_base, wlog_at_done;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    clear_logs();
    base     = done_cnt;
    ack_base = wr_ack_cnt;
    wa = AW'($urandom_range(400000, 524287));
    wd = DW'($urandom);
    start_line($urandom_range(0, V_LINES - 1));
    wr_req  = 1'b1;
    wr_addr = wa;
    wr_data = wd;
    wait_lines(base + 1);
    wlog_at_done = wr_log.size();
    wait_ack(ack_base + 1);
    repeat (5) step();
    checks++;
    if (wlog_at_done !== 0 || wr_ack_cyc <= done_cyc) begin
      errors++;
      $display("FAIL write_held_off: writes before done=%0d ack_cyc=%0d done_cyc=%0d, expected 0 and ack after done",
               wlog_at_done, wr_ack_cyc, done_cyc);
    end
    checks++;
    if (wr_ack_cnt - ack_base !== 1) begin
      errors++;
      $display("FAIL write_ack_once: got %0d ack cycles, expected 1", wr_ack_cnt - ack_base);
    end
    checks++;
    if (wr_log.size() !== 1 || wr_log[0] !== {wa, wd}) begin
      errors++;
      $display("FAIL write_cmd: got %0d writes, expected 1 of %h/%h", wr_log.size(), wa, wd);
    end
    checks++;
    if (lb_diff() != 0) begin
      errors++;
      $display("FAIL write_fetch_lb: %0d bad, got %h expected %h", lb_diff(), bad_act, bad_exp);
    end
  endtask

  task automatic test_same_cycle();
    int base, ack_base, idx;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    clear_logs();
    base = done_cnt;
    ack_base = wr_ack_cnt;
    first_rd_cyc = -1;
    first_wr_cyc = -1;
    wa  = AW'($urandom_range(400000, 524287));
    wd  = DW'($urandom);
    idx = $urandom_range(0, V_LINES - 1);
    expect_line(idx);
    wr_req  = 1'b1;
    wr_addr = wa;
    wr_data = wd;
    pulse_line(idx);
    wait_lines(base + 1);
    wait_ack(ack_base + 1);
    repeat (3) step();
    checks++;
    if (first_rd_cyc < 0 || first_wr_cyc <= done_cyc) begin
      errors++;
      $display("FAIL same_cycle_order: first read cyc %0d, write cyc %0d, line_done cyc %0d, expected read then write after done",
               first_rd_cyc, first_wr_cyc, done_cyc);
    end
    checks++;
    if (wr_log.size() !== 1 || wr_log[0] !== {wa, wd}) begin
      errors++;
      $display("FAIL same_cycle_write: got %0d writes, expected 1 of %h/%h", wr_log.size(), wa, wd);
    end
    checks++;
    if (lb_diff() != 0) begin
      errors++;
      $display("FAIL same_cycle_lb: %0d bad, got %h expected %h", lb_diff(), bad_act, bad_exp);
    end
  endtask

  task automatic test_drop();
    int base, n;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_before_drop: got %b, expected 0", err);
    end
    fixed_lat = 8;
    clear_logs();
    base = done_cnt;
    start_line($urandom_range(0, V_LINES - 1));
    n = 0;
    while (rd_addr_log.size() < H_PIX && n < BUDGET) begin
      step();
      n++;
    end
    step();
    pulse_line($urandom_range(0, V_LINES - 1));
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL drop_in_drain_err: got %b, expected 1", err);
    end
    wait_lines(base + 1);
    repeat (20) step();
    checks++;
    if (done_cnt !== base + 1 || rd_addr_log.size() !== H_PIX) begin
      errors++;
      $display("FAIL drop_in_drain_ignored: got %0d lines %0d reads, expected 1 line %0d reads",
               done_cnt - base, rd_addr_log.size(), H_PIX);
    end
    checks++;
    if (lb_diff() != 0) begin
      errors++;
      $display("FAIL drop_line_lb: %0d bad, got %h expected %h", lb_diff(), bad_act, bad_exp);
    end
    pulse_line(V_LINES);
    repeat (10) step();
    checks++;
    if (rd_addr_log.size() !== H_PIX || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL drop_idx_480: got reads=%0d busy=%b err=%b, expected %0d 0 1",
               rd_addr_log.size(), busy, err, H_PIX);
    end
    fixed_lat = 3;
  endtask

  task automatic test_random_ready();
    int base, ack_base;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    for (int l = 0; l < 3; l++) begin
      clear_logs();
      base = done_cnt;
      start_line(l == 0 ? V_LINES - 1 : int'($urandom_range(0, V_LINES - 1)));
      wait_lines(base + 1);
      repeat (3) step();
      checks++;
      if (addr_diff() != 0) begin
        errors++;
        $display("FAIL rand_addr line %0d: %0d bad (n=%0d), got %0d expected %0d",
                 l, addr_diff(), rd_addr_log.size(), bad_a_act, bad_a_exp);
      end
      checks++;
      if (lb_diff() != 0) begin
        errors++;
        $display("FAIL rand_lb line %0d: %0d bad (n=%0d), got %h expected %h",
                 l, lb_diff(), lb_log.size(), bad_act, bad_exp);
      end
    end
    for (int w = 0; w < 4; w++) begin
      clear_logs();
      ack_base = wr_ack_cnt;
      wa = AW'($urandom_range(400000, 524287));
      wd = DW'($urandom);
      wr_req  = 1'b1;
      wr_addr = wa;
      wr_data = wd;
      wait_ack(ack_base + 1);
      repeat (3) step();
      checks++;
      if (wr_log.size() !== 1 || wr_log[0] !== {wa, wd} || wr_ack_cnt - ack_base !== 1) begin
        errors++;
        $display("FAIL rand_write %0d: got %0d writes %0d acks, expected 1 of %h/%h",
                 w, wr_log.size(), wr_ack_cnt - ack_base, wa, wd);
      end
    end
    checks++;
    if (stall_viol !== 0 || wdata_viol !== 0 || ack_viol !== 0) begin
      errors++;
      $display("FAIL cmd_protocol: stall=%0d rd_wdata=%0d ack=%0d violations, expected 0",
               stall_viol, wdata_viol, ack_viol);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
    rand_ready = 1'b0;
    rand_lat   = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, base;
    logic [LBW-1:0] ent;
    fixed_lat = 3;
    clear_logs();
    start_line($urandom_range(0, V_LINES - 1));
    n = 0;
    while (lb_log.size() < 300 && n < BUDGET) begin
      step();
      n++;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({mem_cmd_valid, mem_cmd_addr, lb_we, lb_addr, lb_bank, lb_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b addr=%h lb_we=%b lb_addr=%0d bank=%b, expected all 0",
               mem_cmd_valid, mem_cmd_addr, lb_we, lb_addr, lb_bank);
    end
    checks++;
    if ({busy, err, line_done, wr_ack, fsm_state} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_status: got busy=%b err=%b done=%b ack=%b state=%0d, expected all 0",
               busy, err, line_done, wr_ack, fsm_state);
    end
    repeat (3) step();
    rstn = 1'b1;
    clear_logs();
    exp_bank = 1'b0;
    base = done_cnt;
    n = 0;
    while (rq.size() > 0 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (lb_log.size() !== 0 || done_cnt !== base) begin
      errors++;
      $display("FAIL stale_returns: got %0d lb writes %0d line_done, expected 0 0",
               lb_log.size(), done_cnt - base);
    end
    start_line($urandom_range(0, V_LINES - 1));
    wait_lines(base + 1);
    repeat (3) step();
    ent = (lb_log.size() > 0) ? lb_log[0] : '1;
    checks++;
    if (ent[LBW-1 -: 12] !== 12'd0) begin
      errors++;
      $display("FAIL fresh_line_start: got bank=%b addr=%0d, expected bank 0 addr 0",
               ent[LBW-1], ent[LBW-2 -: 11]);
    end
    checks++;
    if (lb_diff() != 0) begin
      errors++;
      $display("FAIL fresh_line_lb: %0d bad, got %h expected %h", lb_diff(), bad_act, bad_exp);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin : main
    test_reset();
    test_line_basic();
    test_write_during_fetch();
    test_same_cycle();
    test_drop();
    test_random_ready();
    test_reset_mid();
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
